// File: rtl/fetch_cntrl.sv
// Purpose: instruction fetch controller with one outstanding imem request feeding a DEPTH-entry instruction FIFO.
// Latency: request issued combinationally from pc; instruction visible on inst_* the cycle after imem_rvalid.
// Backpressure: requests are withheld while the buffer is full, so an in-flight response always has a free slot.
module fetch_cntrl #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        redirect_relative,
    output logic        pc_enable,
    output logic        pc_take_br,
    output logic        pc_is_relative_branch,
    output logic [31:0] pc_branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t        state;
    logic [31:0]   tag;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    entry_t        mem [DEPTH];

    logic push;
    logic pop;

    // Request is gated by reset so nothing is issued while reset is held low.
    assign imem_req  = reset && (state == FETCH) && !redirect && (count < DEPTH_C);
    assign imem_addr = pc;
    assign pc_enable = imem_req && imem_gnt;

    assign pc_take_br            = redirect;
    assign pc_is_relative_branch = redirect_relative;
    assign pc_branch_addr        = redirect_addr;

    // A response is only kept if it arrives for a live request and no redirect kills it.
    assign push = (state == WAIT) && imem_rvalid && !redirect;
    assign pop  = inst_valid && inst_ready;

    assign inst_valid = (count != '0);
    assign inst_data  = mem[rd_ptr].data;
    assign inst_pc    = mem[rd_ptr].pc;

    // Fetch FSM: FETCH issues, WAIT collects, DROP swallows the response of a killed request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            tag   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (pc_enable) begin
                        tag   <= pc;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid)
                        state <= FETCH;
                    else if (redirect)
                        state <= DROP;
                end
                DROP: begin
                    if (imem_rvalid)
                        state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Buffer pointers and occupancy; a redirect flushes everything in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset: validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: tag, data: imem_rdata};
    end

endmodule

// File: doc/fetch_cntrl.md
FETCH_CNTRL -- requirements
Module: fetch_cntrl

Interface
REQ-001 SHALL have parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc  input  32  current PC from pc_cntrl.
REQ-005 SHALL have port redirect  input  1  taken branch resolved downstream, single-cycle pulse.
REQ-006 SHALL have port redirect_addr  input  32  branch target or offset.
REQ-007 SHALL have port redirect_relative  input  1  redirect_addr is PC-relative.
REQ-008 SHALL have port pc_enable  output  1  advance pc_cntrl one step.
REQ-009 SHALL have port pc_take_br  output  1  load branch into pc_cntrl.
REQ-010 SHALL have port pc_is_relative_branch  output  1  relative-branch select to pc_cntrl.
REQ-011 SHALL have port pc_branch_addr  output  32  branch address to pc_cntrl.
REQ-012 SHALL have port imem_req  output  1  instruction memory request.
REQ-013 SHALL have port imem_addr  output  32  request address.
REQ-014 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-015 SHALL have port imem_rvalid  input  1  read data valid; earliest one cycle after gnt.
REQ-016 SHALL have port imem_rdata  input  32  instruction word.
REQ-017 SHALL have port inst_valid  output  1  buffer head valid to decode.
REQ-018 SHALL have port inst_data  output  32  head instruction.
REQ-019 SHALL have port inst_pc  output  32  head instruction address.
REQ-020 SHALL have port inst_ready  input  1  decode accepts head.

Function
REQ-021 SHALL implement FSM states FETCH, WAIT, DROP; max one outstanding memory request.
REQ-022 SHALL drive imem_addr = pc combinationally; imem_req = (state==FETCH) && !redirect && (count < DEPTH).
REQ-023 SHALL assert pc_enable exactly in cycles where imem_req && imem_gnt; capture pc as pending tag; FETCH->WAIT.
REQ-024 SHALL hold imem_req and imem_addr stable in FETCH until gnt or redirect.
REQ-025 WAIT + imem_rvalid (no redirect): push {tag, imem_rdata} into buffer; WAIT->FETCH.
REQ-026 SHALL drive pc_take_br = redirect, pc_is_relative_branch = redirect_relative, pc_branch_addr = redirect_addr combinationally.
REQ-027 Redirect in any state: flush buffer (count=0, inst_valid=0 next cycle), pc_enable=0 that cycle.
REQ-028 Redirect in FETCH -> FETCH; request resumes next cycle with updated pc.
REQ-029 Redirect in WAIT without rvalid -> DROP; redirect in WAIT with rvalid -> FETCH, data discarded.
REQ-030 DROP: discard next imem_rvalid, then -> FETCH; redirect in DROP stays DROP unless rvalid same cycle (-> FETCH).
REQ-031 Buffer: FIFO, inst_valid = (count!=0), pop on inst_valid && inst_ready; simultaneous push and pop leaves count unchanged.
REQ-032 Admission rule (count + outstanding <= DEPTH) SHALL guarantee no overflow; push while full SHALL never occur.
REQ-033 Pointers SHALL wrap modulo DEPTH; count width clog2(DEPTH)+1.
REQ-034 inst_data/inst_pc SHALL be stable while inst_valid && !inst_ready.

Reset
REQ-035 reset low SHALL immediately force state FETCH, count 0, pointers 0, inst_valid 0, imem_req 0, pc_enable 0.
REQ-036 Reset mid-request SHALL abandon the outstanding request; an imem_rvalid in the first cycle after release SHALL be ignored.
REQ-037 First request SHALL be issued the first cycle after reset deasserts.

Verification
REQ-038 Streaming: gnt always 1, rvalid 1 cycle later, inst_ready=1 -> one instruction per 2 cycles, inst_pc 0,1,2... matching pc.
REQ-039 Backpressure: inst_ready=0, DEPTH=2 -> exactly 2 entries buffered, imem_req low, pc_enable never asserted until pop.
REQ-040 Redirect in WAIT: redirect_addr=3, relative=0 -> pc_take_br=1 that cycle, late rvalid dropped, next inst_pc=3.
REQ-041 Redirect coincident with rvalid and a full buffer -> buffer empty next cycle, no push, FSM in FETCH.
REQ-042 Gnt stall: imem_gnt low 5 cycles -> imem_addr constant, pc_enable 0 throughout, one push after grant.
REQ-043 Async reset asserted in WAIT -> outputs cleared without clock edge; post-release stray rvalid ignored.
